// File: rtl/audio_fifo_i2s_tx_if.sv
//------------------------------------------------------------------------------
// Module      : audio_fifo_i2s_tx_if
// Description : Avalon-ST handshake bundle between the playback FIFO
//               (fifo_0_out_*) and the I2S transmitter sink.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface audio_fifo_i2s_tx_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  // FIFO side drives valid/data and observes ready
  modport master (output in_valid, output in_data, input in_ready);
  // Transmitter side observes valid/data and drives ready
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

`default_nettype wire

// File: rtl/audio_fifo_i2s_tx.sv
//------------------------------------------------------------------------------
// Module      : audio_fifo_i2s_tx
// Description : Avalon-ST sink that fetches one 32-bit stereo word per frame
//               and serializes it as an I2S master (BCLK, DACLRCK, DACDAT).
//               Starved frames play silence and are counted.
//               Optional macro AUDIO_I2S_TX_HOLD_LAST_EN: on underflow the
//               previous sample repeats instead of silence.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module audio_fifo_i2s_tx #(
  parameter int BCLK_DIV = 16   // BCLK half-period in clk_50 cycles, 2..255
) (
  input  wire                  clk_50,
  input  wire                  reset_n,
  input  wire                  enable,
  audio_fifo_i2s_tx_if.slave   sink,
  output logic                 aud_bclk,
  output logic                 aud_daclrck,
  output logic                 aud_dacdat,
  output logic                 underflow,
  output logic [15:0]          underflow_cnt
);

  localparam logic [7:0]  c_div_last = 8'(BCLK_DIV - 1);
  localparam logic [4:0]  c_last_bit = 5'd31;
  localparam logic [15:0] c_cnt_max  = 16'hFFFF;

  logic [7:0]  r_div_cnt;
  logic        r_bclk;
  logic [4:0]  r_bit_cnt;
  logic [31:0] r_frame;
  logic        r_lsb_hold;
  logic        r_lrck;
  logic        r_dat;
  logic        r_uf;
  logic [15:0] r_uf_cnt;

  logic        w_div_wrap;
  logic        w_fall_tick;
  logic        w_frame_start;
  logic [4:0]  w_bit_next;
  logic        w_fetch;
  logic        w_starve;

  assign w_div_wrap    = (r_div_cnt == c_div_last);
  assign w_fall_tick   = w_div_wrap & r_bclk;
  assign w_frame_start = w_fall_tick & (r_bit_cnt == c_last_bit);
  assign w_bit_next    = r_bit_cnt + 5'd1;
  // Ready is offered only in the single frame-start cycle, gated by enable
  assign w_fetch       = w_frame_start & enable;
  assign w_starve      = w_fetch & ~sink.in_valid;

  assign sink.in_ready = w_fetch;
  assign aud_bclk      = r_bclk;
  assign aud_daclrck   = r_lrck;
  assign aud_dacdat    = r_dat;
  assign underflow     = r_uf;
  assign underflow_cnt = r_uf_cnt;

  // Bit-clock divider: toggle BCLK every BCLK_DIV fabric cycles
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
    end else if (w_div_wrap) begin
      r_div_cnt <= '0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

  // Frame position, word select and serial data, all updated on BCLK fall
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt  <= c_last_bit;
      r_lrck     <= 1'b0;
      r_dat      <= 1'b0;
      r_lsb_hold <= 1'b0;
    end else if (w_fall_tick) begin
      r_bit_cnt <= w_bit_next;
      r_lrck    <= w_bit_next[4];
      // Bit n-1 of the frame lives at index 31-(n-1), i.e. ~old bit_cnt;
      // n = 0 instead replays right[0] of the word just finished.
      if (w_frame_start) begin
        r_dat <= r_lsb_hold;
      end else begin
        r_dat <= r_frame[~r_bit_cnt];
      end
      // Capture right[0] before the frame register is reloaded
      if (r_bit_cnt == 5'd30) begin
        r_lsb_hold <= r_frame[0];
      end
    end
  end

  // Frame register: load the fetched word, silence, or (optionally) hold
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_frame <= '0;
    end else if (w_frame_start) begin
      if (!enable) begin
        r_frame <= '0;
      end else if (sink.in_valid) begin
        r_frame <= sink.in_data;
      end else begin
`ifdef AUDIO_I2S_TX_HOLD_LAST_EN
        r_frame <= r_frame;
`else
        r_frame <= '0;
`endif
      end
    end
  end

  // Underflow pulse and saturating starved-frame counter
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_uf     <= 1'b0;
      r_uf_cnt <= '0;
    end else begin
      r_uf <= w_starve;
      if (w_starve && (r_uf_cnt != c_cnt_max)) begin
        r_uf_cnt <= r_uf_cnt + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_audio_fifo_i2s_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_audio_fifo_i2s_tx
// Description : Self-checking bench for audio_fifo_i2s_tx (BCLK_DIV = 2).
//               Reference: frame timing from cycle arithmetic, data checked
//               by an I2S receiver decoding words against an expected queue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_audio_fifo_i2s_tx;

  localparam int DIV   = 2;
  localparam int FIRST = 2 * DIV;   // cycle of the first in_ready pulse
  localparam int FRAME = 64 * DIV;  // cycles per frame

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        aud_bclk, aud_daclrck, aud_dacdat, underflow;
  logic [15:0] underflow_cnt;

  audio_fifo_i2s_tx_if bus ();

  audio_fifo_i2s_tx #(.BCLK_DIV(DIV)) dut (
    .clk_50        (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .sink          (bus),
    .aud_bclk      (aud_bclk),
    .aud_daclrck   (aud_daclrck),
    .aud_dacdat    (aud_dacdat),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Edges since reset release
  int cyc = 0;
  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic bit is_fetch(input int c);
    return (c >= FIRST) && (((c - FIRST) % FRAME) == 0);
  endfunction

  // Reference model state
  logic [31:0] exp_q[$];
  logic [31:0] m_frame;
  logic [15:0] m_uf_cnt;
  logic        m_uf_pend;
  int          first_rdy_c, prev_rdy_c, last_gap, d_words;
  logic        d_prev_bclk, d_prev_lrck, d_have_left;
  logic [15:0] d_sh, d_left;

  // Per-cycle comparison against the reference model plus I2S decoding
  always @(negedge clk) begin
    int          c, e, f;
    bit          fetch, exp_rdy, exp_lrck;
    logic [15:0] w16;
    logic [31:0] want;
    if (!reset_n) begin
      exp_q.delete();
      m_frame = '0; m_uf_cnt = '0; m_uf_pend = 1'b0;
      first_rdy_c = -1; prev_rdy_c = -1; last_gap = -1;
      d_prev_bclk = 1'b0; d_prev_lrck = 1'b0; d_have_left = 1'b0;
      d_sh = '0; d_left = '0;
    end else begin
      e = cyc;
      c = cyc + 1;
      f = e / (2 * DIV);
      fetch    = is_fetch(c);
      exp_rdy  = fetch && enable;
      exp_lrck = (f == 0) ? 1'b0 : (((31 + f) % 32) >= 16);
      check("in_ready", bus.in_ready, exp_rdy);
      check("underflow", underflow, m_uf_pend);
      check("underflow_cnt", underflow_cnt, m_uf_cnt);
      check("aud_bclk", aud_bclk, ((e / DIV) % 2) == 1);
      check("aud_daclrck", aud_daclrck, exp_lrck);

      if (bus.in_ready) begin
        if (first_rdy_c < 0) first_rdy_c = c;
        if (prev_rdy_c >= 0) last_gap = c - prev_rdy_c;
        prev_rdy_c = c;
      end

      // Codec-side receiver: sample data on each BCLK rise
      if (aud_bclk && !d_prev_bclk) begin
        w16 = {d_sh[14:0], aud_dacdat};
        if (aud_daclrck != d_prev_lrck) begin
          if (!d_prev_lrck) begin
            d_left = w16;
            d_have_left = 1'b1;
          end else if (d_have_left) begin
            if (exp_q.size() == 0) begin
              check("i2s_queue_len", 32'(exp_q.size()), 32'd1);
            end else begin
              want = exp_q.pop_front();
              check("i2s_word", {d_left, w16}, want);
              d_words++;
            end
            d_have_left = 1'b0;
          end
        end
        d_sh = w16;
        d_prev_lrck = aud_daclrck;
      end
      d_prev_bclk = aud_bclk;

      // Advance the model past this cycle's edge
      m_uf_pend = 1'b0;
      if (fetch) begin
        if (enable && bus.in_valid) begin
          m_frame = bus.in_data;
        end else if (enable) begin
          m_uf_pend = 1'b1;
          if (m_uf_cnt != 16'hFFFF) m_uf_cnt = m_uf_cnt + 16'd1;
`ifndef AUDIO_I2S_TX_HOLD_LAST_EN
          m_frame = '0;
`endif
        end else begin
          m_frame = '0;
        end
        exp_q.push_back(m_frame);
      end
    end
  end

  // Advance to just after the next frame-start edge
  task automatic next_frame();
    int k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!is_fetch(cyc + 1) && k < 4 * FRAME);
    if (k >= 4 * FRAME) check("frame_wait_timeout", 32'(k), 32'(FRAME));
    @(posedge clk); #1;
  endtask

  task automatic play(input logic v, input logic [31:0] d, input logic en);
    bus.in_valid = v;
    bus.in_data  = d;
    enable       = en;
    next_frame();
  endtask

  initial begin
    logic [15:0] saved_cnt;
    int          e0, k;
    d_words = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h8001_7FFE;
    enable = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_ready", bus.in_ready, 1'b0);
    check("rst_bclk", aud_bclk, 1'b0);
    check("rst_cnt", underflow_cnt, 16'h0);
    reset_n = 1'b1;

    // Known pattern, then back-to-back words
    play(1'b1, 32'h8001_7FFE, 1'b1);
    check("first_ready_cycle", 32'(first_rdy_c), 32'(FIRST));
    play(1'b1, 32'h1234_5678, 1'b1);
    play(1'b1, 32'hA5A5_0F0F, 1'b1);
    check("ready_gap", 32'(last_gap), 32'(FRAME));

    // Starved frame
    play(1'b0, 32'hDEAD_BEEF, 1'b1);
    check("uf_pulse", underflow, 1'b1);
    check("uf_cnt_first", underflow_cnt, 16'd1);
    play(1'b1, 32'h0F0F_F0F0, 1'b1);

    // Randomized frames with mid-frame enable changes
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = $urandom;
      repeat ($urandom_range(5, 60)) @(posedge clk);
      #1;
      enable = ($urandom_range(0, 3) != 0);
      next_frame();
    end

    // Disabled for three frames: no fetch, no underflow, clocks keep going
    saved_cnt = m_uf_cnt;
    for (int i = 0; i < 3; i++) play(1'b1, $urandom, 1'b0);
    check("uf_cnt_disabled", underflow_cnt, saved_cnt);
    play(1'b1, 32'h5555_AAAA, 1'b1);

    // Valid only mid-frame: counted as underflow at the next frame start
    saved_cnt = m_uf_cnt;
    bus.in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    next_frame();
    check("midpulse_uf", underflow, 1'b1);
    check("midpulse_cnt", underflow_cnt, saved_cnt + 16'd1);

    // Saturation
    force dut.r_uf_cnt = 16'hFFFE;
    m_uf_cnt = 16'hFFFE;
    #1;
    release dut.r_uf_cnt;
    for (int i = 0; i < 3; i++) play(1'b0, 32'h0, 1'b1);
    check("uf_saturated", underflow_cnt, 16'hFFFF);

    // Asynchronous reset at bit 20
    play(1'b1, $urandom, 1'b1);
    e0 = cyc;
    k = 0;
    while (cyc < e0 + 2 * DIV * 20 && k < FRAME) begin
      @(posedge clk); #1;
      k++;
    end
    check("lrck_at_n20", aud_daclrck, 1'b1);
    reset_n = 1'b0;
    #1;
    check("arst_ready", bus.in_ready, 1'b0);
    check("arst_bclk", aud_bclk, 1'b0);
    check("arst_lrck", aud_daclrck, 1'b0);
    check("arst_dat", aud_dacdat, 1'b0);
    check("arst_uf", underflow, 1'b0);
    check("arst_cnt", underflow_cnt, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    play(1'b1, $urandom, 1'b1);
    check("first_ready_after_rst", 32'(first_rdy_c), 32'(FIRST));
    for (int i = 0; i < 4; i++) play($urandom_range(0, 3) != 0, $urandom, 1'b1);
    play(1'b1, 32'h0, 1'b1);

    check("i2s_words_seen", 32'(d_words >= 20), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
